noc_sync_injector: RTL
======================

// Module: noc_sync_injector
// PURPOSE
//  Clocked packet source/network interface that feeds the upstream port of the router input stage.
//  Buffers flits from a synchronous core, then emits them as 2-phase bundled data (req_o toggle, data_o stable).
//  Completes each transfer only when the synchronized ack_i toggle matches req_o.
//  Sits between the core clock domain and the asynchronous (MouseTrap) router pipeline.
// PARAMETERS
//  WIDTH        32  flit width; equals router bundled-data width
//  DEPTH        8   flit FIFO entries, power of 2, >=2
//  COORD_W      4   bits per destination coordinate in head flit
//  SETUP_CYC    1   cycles data_o is held stable before req_o toggles (bundling margin), >=1
//  CNT_W        16  width of statistics counters
// PORTS
//  clk           in   1        core clock
//  reset         in   1        synchronous, active-low reset
//  inject_en     in   1        permit injection; sampled only at packet boundaries
//  in_valid      in   1        core flit valid
//  in_data       in   WIDTH    core flit
//  in_ready      out  1        FIFO can accept (!full)
//  req_o         out  1        2-phase request to router input port
//  data_o        out  WIDTH    bundled data, stable while req_o != ack
//  ack_i         in   1        2-phase ack from router (async, synchronized internally)
//  busy_o        out  1        state != IDLE
//  flits_sent_o  out  CNT_W    acknowledged flits, wraps
//  pkts_sent_o   out  CNT_W    acknowledged TAIL/SINGLE flits, wraps
// BEHAVIOUR
//  Reset (reset==0 at posedge): req_o=0, data_o=0, in_ready=0 during reset and 1 from the first cycle after.
//   Also: busy_o=0, counters=0, FIFO empty, synchronizer flops=0, state IDLE, in_pkt=0.
//  Reset mid-transfer abandons the flit; the router is reset together with this block (ack returns to 0).
//  Flit type = in_data[WIDTH-1:WIDTH-2]: 10 HEAD, 00 BODY, 01 TAIL, 11 SINGLE (head+tail).
//  Head dest: X=[2*COORD_W-1:COORD_W], Y=[COORD_W-1:0]; carried unmodified; no type checking on input.
//  Push: in_valid&&in_ready writes FIFO. in_ready is derived from registered count only.
//   When full, a same-cycle pop does not raise in_ready until the next cycle.
//  ack_s = 2-flop synchronized ack_i; transfer outstanding while req_o != ack_s.
//  FSM:
//   IDLE:  FIFO non-empty && (in_pkt || inject_en) -> load data_o<=FIFO head, setup counter=0 -> SETUP.
//   SETUP: data_o held; after SETUP_CYC cycles toggle req_o -> WAIT.
//   WAIT:  when ack_s==req_o: pop FIFO; flits_sent_o++; if type TAIL/SINGLE, pkts_sent_o++ and in_pkt<=0,
//          else in_pkt<=1; -> IDLE.
//  Latency: flit at FIFO head in IDLE -> req_o toggle after 1+SETUP_CYC cycles.
//   Min per-flit period = 1+SETUP_CYC+2 (sync) + router ack delay.
//  inject_en=0 never splits a packet: deassertion mid-packet takes effect after the tail is acknowledged.
//  data_o changes only in IDLE->SETUP; never while a transfer is outstanding.
//  ack_s toggling while req_o==ack_s (spurious) is ignored; no state change.
//  Counters wrap at 2^CNT_W silently. FIFO pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
// STRUCTURE
//  Package noc_flit_pkg: flit_type_e {BODY=2'b00,TAIL=2'b01,HEAD=2'b10,SINGLE=2'b11}, TYPE_MSB/LSB,
//   coordinate field helper functions, is_tail() function.
//  Sub-module flit_fifo #(WIDTH,DEPTH): synchronous FIFO with push/pop/full/empty/head;
//   same-cycle push+pop allowed when not full.
//  2-flop ack synchronizer and FSM are inline in this module.
// TESTING
//  1. Reset, push SINGLE 0xC000_0021, ack_i echoes req_o after 3 cycles
//     -> req_o 0->1 at cycle 2 (SETUP_CYC=1), data_o=0xC000_0021; flits=1, pkts=1, busy_o=0 after.
//  2. Push HEAD,BODY,BODY,TAIL with inject_en=1, drop inject_en after HEAD acked
//     -> all 4 flits sent in order, pkts=1, then no further injection while inject_en=0.
//  3. Fill FIFO with 8 flits, ack held -> in_ready=0, 9th push ignored.
//     Release ack -> in_ready=1 one cycle after first pop, order preserved.
//  4. Spurious ack_i toggle while IDLE with empty FIFO -> no req_o change, counters unchanged.
//  5. Assert reset in WAIT with 2 flits queued -> req_o=0, data_o=0, counters 0, FIFO empty next cycle.
//  6. Run 70000 SINGLE flits, CNT_W=16 -> flits_sent_o = 70000 mod 65536 = 4464; data_o stable whenever req_o != ack_s.

Source files
------------

// File: rtl/noc_flit_pkg.sv
// Flit format definitions shared by the injector and its FIFO.
package noc_flit_pkg;

    // Two-bit flit type carried in the top bits of every flit
    typedef enum logic [1:0] {
        BODY   = 2'b00,
        TAIL   = 2'b01,
        HEAD   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    localparam int unsigned FLIT_W   = 32;
    localparam int unsigned TYPE_MSB = FLIT_W - 1;
    localparam int unsigned TYPE_LSB = FLIT_W - 2;

    // Type field position for an arbitrary flit width
    function automatic int unsigned type_msb(input int unsigned w);
        return w - 1;
    endfunction

    function automatic int unsigned type_lsb(input int unsigned w);
        return w - 2;
    endfunction

    // Head-flit destination field positions: X above Y, each cw bits
    function automatic int unsigned dest_x_msb(input int unsigned cw);
        return 2 * cw - 1;
    endfunction

    function automatic int unsigned dest_x_lsb(input int unsigned cw);
        return cw;
    endfunction

    function automatic int unsigned dest_y_msb(input int unsigned cw);
        return cw - 1;
    endfunction

    // TAIL and SINGLE both close a packet
    function automatic logic is_tail(input flit_type_e t);
        return (t == TAIL) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/noc_sync_injector_if.sv
// Core-side flit stream: valid/data from the core, ready back from the injector.
interface noc_sync_injector_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/flit_fifo.sv
// Synchronous flit FIFO; push and pop may coincide whenever it is not full.
module flit_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage array, not reset: emptiness is tracked by the count alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap modulo DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/noc_sync_injector.sv
// Buffers core flits and emits them as 2-phase bundled data towards the router.
module noc_sync_injector
    import noc_flit_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inject_en,
    noc_sync_injector_if.slave   core,
    output logic                 req_o,
    output logic [WIDTH-1:0]     data_o,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     flits_sent_o,
    output logic [CNT_W-1:0]     pkts_sent_o
);
    localparam int unsigned T_MSB = type_msb(WIDTH);
    localparam int unsigned T_LSB = type_lsb(WIDTH);
    localparam int unsigned SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

    if (SETUP_CYC < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        dest_x_msb(COORD_W) >= T_LSB) begin : g_bad_params
        $error("noc_sync_injector: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT} state_e;

    state_e           r_state;
    logic [SET_W-1:0] r_setup_cnt;
    logic [1:0]       r_ack_sync;
    logic             r_live;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_in_pkt;
    logic [CNT_W-1:0] r_flits;
    logic [CNT_W-1:0] r_pkts;

    logic             w_ack_s;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic             w_in_ready;
    logic             w_push;
    logic             w_done;
    logic             w_start;

    assign w_ack_s    = r_ack_sync[1];
    assign w_in_ready = r_live && !w_full;
    assign w_push     = core.in_valid && w_in_ready;
    assign w_done     = (r_state == S_WAIT) && (w_ack_s == r_req);
    assign w_start    = (r_state == S_IDLE) && !w_empty && (r_in_pkt || inject_en);

    flit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_done),
        .i_din   (core.in_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Ack synchronizer and the out-of-reset flag that gates in_ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ack_sync <= 2'b00;
            r_live     <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[0], ack_i};
            r_live     <= 1'b1;
        end
    end

    // Transfer FSM: load head, hold it for the bundling margin, toggle req, await matching ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_setup_cnt <= '0;
            r_req       <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_flits     <= '0;
            r_pkts      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_data      <= w_head;
                        r_setup_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_setup_cnt == SET_W'(SETUP_CYC - 1)) begin
                        r_req   <= ~r_req;
                        r_state <= S_WAIT;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + SET_W'(1);
                    end
                end
                S_WAIT: begin
                    if (w_done) begin
                        r_flits <= r_flits + CNT_W'(1);
                        if (is_tail(flit_type_e'(r_data[T_MSB:T_LSB]))) begin
                            r_pkts   <= r_pkts + CNT_W'(1);
                            r_in_pkt <= 1'b0;
                        end else begin
                            r_in_pkt <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core.in_ready = w_in_ready;
    assign req_o         = r_req;
    assign data_o        = r_data;
    assign busy_o        = r_busy;
    assign flits_sent_o  = r_flits;
    assign pkts_sent_o   = r_pkts;
endmodule
